// File: rtl/window_scan_ctrl.sv
// Scan sequencer: streams a frame out of fixed-latency memory column by column,
// assembles 5x5 windows, and tags each window so its datapath result is written back.
module window_scan_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int ADDR_W   = 10,
  parameter int RES_AW   = 10,
  parameter int PIPE_LAT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_data,
  output logic [199:0]        win_taps,
  output logic                win_valid,
  input  logic [7:0]          res_in,
  output logic                res_valid,
  output logic [RES_AW-1:0]   res_addr,
  output logic [7:0]          res_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] COL_BACK  = ADDR_W'(4 * IMG_W - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     LAST_WROW = RW'(IMG_H - 5);

  logic [1:0]            state;
  logic [2:0]            rd_sub;
  logic [CW-1:0]         rd_col;
  logic [RW-1:0]         rd_wrow;
  logic                  last_rd;

  logic                  vld_p0;
  logic [2:0]            sub_p0;
  logic [7:0]            stage_p0 [4];
  logic [24:0][7:0]      taps_p1;
  logic [CW-1:0]         col_cnt;

  logic [RES_AW-1:0]     win_idx;
  logic [PIPE_LAT-1:0]   tag_vld_p2;
  logic [RES_AW-1:0]     tag_addr_p2 [PIPE_LAT];
  logic                  pipe_empty;

  assign last_rd    = (rd_sub == 3'd4) && (rd_col == LAST_COL) && (rd_wrow == LAST_WROW);
  assign pipe_empty = !vld_p0 && !win_valid && !(|tag_vld_p2);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign win_taps   = taps_p1;

  // Read sequencer: 5 reads down a column, then step back up and right one column.
  // The same step-back lands on the next window row after the last column.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      rd_sub   <= '0;
      rd_col   <= '0;
      rd_wrow  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            mem_rd   <= 1'b1;
            mem_addr <= '0;
            rd_sub   <= '0;
            rd_col   <= '0;
            rd_wrow  <= '0;
          end
        end
        S_FETCH: begin
          if (last_rd) begin
            mem_rd <= 1'b0;
            state  <= S_DRAIN;
          end else if (rd_sub == 3'd4) begin
            rd_sub   <= '0;
            mem_addr <= mem_addr - COL_BACK;
            if (rd_col == LAST_COL) begin
              rd_col  <= '0;
              rd_wrow <= rd_wrow + RW'(1);
            end else begin
              rd_col <= rd_col + CW'(1);
            end
          end else begin
            rd_sub   <= rd_sub + 3'd1;
            mem_addr <= mem_addr + ROW_STEP;
          end
        end
        S_DRAIN: begin
          if (pipe_empty) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: memory data returns; stage p1: column commit into the window
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      sub_p0    <= '0;
      for (int i = 0; i < 4; i++) stage_p0[i] <= '0;
      taps_p1   <= '0;
      col_cnt   <= '0;
      win_valid <= 1'b0;
    end else begin
      vld_p0    <= mem_rd;
      sub_p0    <= rd_sub;
      win_valid <= 1'b0;
      if (vld_p0) begin
        if (sub_p0 != 3'd4) begin
          stage_p0[sub_p0[1:0]] <= mem_data;
        end else begin
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) taps_p1[r*5+c] <= taps_p1[r*5+c+1];
          end
          taps_p1[4]  <= stage_p0[0];
          taps_p1[9]  <= stage_p0[1];
          taps_p1[14] <= stage_p0[2];
          taps_p1[19] <= stage_p0[3];
          taps_p1[24] <= mem_data;
          // A window is complete once five columns of the current row are in.
          if (col_cnt == LAST_COL) begin
            col_cnt   <= '0;
            win_valid <= 1'b1;
          end else begin
            col_cnt   <= col_cnt + CW'(1);
            win_valid <= (col_cnt >= CW'(4));
          end
        end
      end
    end
  end

  // Stage p2: tag delay line matching the datapath latency, then result write
  always_ff @(posedge clk) begin
    if (rst) begin
      win_idx    <= '0;
      tag_vld_p2 <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_addr_p2[i] <= '0;
      res_valid  <= 1'b0;
      res_addr   <= '0;
      res_data   <= '0;
    end else begin
      if (state == S_IDLE && start) win_idx <= '0;
      else if (win_valid)           win_idx <= win_idx + RES_AW'(1);
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        tag_vld_p2[i]  <= tag_vld_p2[i-1];
        tag_addr_p2[i] <= tag_addr_p2[i-1];
      end
      tag_vld_p2[0]  <= win_valid;
      tag_addr_p2[0] <= win_idx;
      res_valid      <= tag_vld_p2[PIPE_LAT-1];
      if (tag_vld_p2[PIPE_LAT-1]) begin
        res_addr <= tag_addr_p2[PIPE_LAT-1];
        res_data <= res_in;
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: three frame geometries/latencies checked against a
// per-window reference model built from the scan rules and the memory contents.
module tb_window_scan_ctrl;

  localparam int NI = 3;
  localparam int WV [NI] = '{5, 28, 9};
  localparam int HV [NI] = '{5, 28, 7};
  localparam int LV [NI] = '{3, 6, 9};

  typedef struct {
    int           cyc;
    int           a;
    int           d;
    logic [199:0] t;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   base [NI] = '{0, 0, 0};
  int   checks = 0;
  int   errors = 0;

  logic         start     [NI];
  logic         busy      [NI];
  logic         done      [NI];
  logic         mem_rd    [NI];
  logic [9:0]   mem_addr  [NI];
  logic [7:0]   mem_data  [NI];
  logic [199:0] win_taps  [NI];
  logic         win_valid [NI];
  logic [7:0]   res_in    [NI];
  logic         res_valid [NI];
  logic [9:0]   res_addr  [NI];
  logic [7:0]   res_data  [NI];

  logic [7:0] memc [NI][1024];

  ev_t rd_q   [NI][$];
  ev_t win_q  [NI][$];
  ev_t res_q  [NI][$];
  ev_t done_q [NI][$];
  ev_t busy_q [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = LV[g];
    logic [7:0] dl [L];
    ev_t e_m;

    window_scan_ctrl #(
      .IMG_W(WV[g]), .IMG_H(HV[g]), .ADDR_W(10), .RES_AW(10), .PIPE_LAT(L)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]), .mem_data(mem_data[g]),
      .win_taps(win_taps[g]), .win_valid(win_valid[g]), .res_in(res_in[g]),
      .res_valid(res_valid[g]), .res_addr(res_addr[g]), .res_data(res_data[g])
    );

    // One-cycle frame memory and a datapath that returns the centre tap after L cycles.
    always @(posedge clk) begin
      if (mem_rd[g] === 1'b1) mem_data[g] <= memc[g][mem_addr[g]];
      dl[0] <= win_taps[g][103:96];
      for (int j = 1; j < L; j++) dl[j] <= dl[j-1];
    end
    assign res_in[g] = dl[L-1];

    always @(negedge clk) begin
      e_m.cyc = cyc - base[g] + 1;
      e_m.a = 0; e_m.d = 0; e_m.t = '0;
      if (mem_rd[g] === 1'b1) begin e_m.a = int'(mem_addr[g]); rd_q[g].push_back(e_m); end
      e_m.a = 0;
      if (win_valid[g] === 1'b1) begin e_m.t = win_taps[g]; win_q[g].push_back(e_m); end
      e_m.t = '0;
      if (res_valid[g] === 1'b1) begin
        e_m.a = int'(res_addr[g]); e_m.d = int'(res_data[g]); res_q[g].push_back(e_m);
      end
      e_m.a = 0; e_m.d = 0;
      if (done[g] === 1'b1) done_q[g].push_back(e_m);
      if (busy[g] === 1'b1) busy_q[g].push_back(e_m);
    end
  end

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q(input int i);
    rd_q[i].delete(); win_q[i].delete(); res_q[i].delete();
    done_q[i].delete(); busy_q[i].delete();
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_busy"},      busy[i],      0);
      check({tag, "_done"},      done[i],      0);
      check({tag, "_mem_rd"},    mem_rd[i],    0);
      check({tag, "_mem_addr"},  mem_addr[i],  0);
      check({tag, "_win_taps"},  win_taps[i],  0);
      check({tag, "_win_valid"}, win_valid[i], 0);
      check({tag, "_res_valid"}, res_valid[i], 0);
      check({tag, "_res_addr"},  res_addr[i],  0);
      check({tag, "_res_data"},  res_data[i],  0);
    end
  endtask

  function automatic logic all_done();
    for (int i = 0; i < NI; i++) if (done_q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: every read, window, result and the done/busy span of one frame scan.
  task automatic verify(input int i);
    int W, H, L, k, idx, wc, last_wc, done_c;
    logic [199:0] et;
    string p;
    W = WV[i]; H = HV[i]; L = LV[i];
    p = $sformatf("u%0d_", i);
    check({p, "rd_count"}, rd_q[i].size(), 5 * W * (H - 4));
    k = 0;
    for (int r = 0; r <= H - 5; r++)
      for (int c = 0; c < W; c++)
        for (int s = 0; s < 5; s++) begin
          if (k < rd_q[i].size()) begin
            check({p, "rd_addr"}, rd_q[i][k].a, (r + s) * W + c);
            check({p, "rd_cyc"},  rd_q[i][k].cyc, k + 1);
          end
          k++;
        end
    check({p, "win_count"}, win_q[i].size(), (W - 4) * (H - 4));
    check({p, "res_count"}, res_q[i].size(), (W - 4) * (H - 4));
    last_wc = 0;
    for (int r = 0; r <= H - 5; r++)
      for (int c = 0; c <= W - 5; c++) begin
        idx = r * (W - 4) + c;
        wc  = r * 5 * W + 5 * c + 27;
        last_wc = wc;
        for (int t = 0; t < 25; t++) et[8*t +: 8] = memc[i][(r + t / 5) * W + c + t % 5];
        if (idx < win_q[i].size()) begin
          check({p, "win_cyc"},  win_q[i][idx].cyc, wc);
          check({p, "win_taps"}, win_q[i][idx].t, et);
        end
        if (idx < res_q[i].size()) begin
          check({p, "res_cyc"},  res_q[i][idx].cyc, wc + L + 1);
          check({p, "res_addr"}, res_q[i][idx].a, idx);
          check({p, "res_data"}, res_q[i][idx].d, memc[i][(r + 2) * W + c + 2]);
        end
      end
    done_c = last_wc + L + 2;
    check({p, "done_count"}, done_q[i].size(), 1);
    if (done_q[i].size() > 0) check({p, "done_cyc"}, done_q[i][0].cyc, done_c);
    check({p, "busy_cycles"}, busy_q[i].size(), done_c);
    if (busy_q[i].size() > 0) check({p, "busy_first"}, busy_q[i][0].cyc, 1);
  endtask

  initial begin
    int rel;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 1024; a++)
        memc[i][a] = (i == 0) ? 8'(a) : 8'($urandom);
    repeat (3) step();
    // Start together with reset must be ignored.
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    check_zero("reset");
    rst = 1'b0;
    step();
    for (int i = 0; i < NI; i++) clear_q(i);

    // Full scans on all three instances; instance 1 and 2 get start re-pulses mid-scan.
    for (int i = 0; i < NI; i++) start[i] = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin base[i] = cyc; start[i] = 1'b0; end
    for (int t = 0; t < 6000 && !all_done(); t++) begin
      step();
      rel = cyc - base[1] + 1;
      start[1] = (rel == 10 || rel == 500);
      start[2] = (cyc - base[2] + 1 == 10);
    end
    start[1] = 1'b0; start[2] = 1'b0;
    check("scan_timeout", all_done(), 1'b1);
    repeat (5) step();
    for (int i = 0; i < NI; i++) verify(i);

    // Reset in the middle of a 28x28 scan, then a fresh scan.
    clear_q(1);
    start[1] = 1'b1;
    step();
    base[1] = cyc; start[1] = 1'b0;
    for (int t = 0; t < 200 && (cyc - base[1] + 1) < 100; t++) step();
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    clear_q(1);
    repeat (10) step();
    check("midrst_no_rd",  rd_q[1].size(),  0);
    check("midrst_no_res", res_q[1].size(), 0);
    check("midrst_idle",   busy_q[1].size(), 0);
    clear_q(1);
    start[1] = 1'b1;
    step();
    base[1] = cyc; start[1] = 1'b0;
    for (int t = 0; t < 6000 && done_q[1].size() == 0; t++) step();
    check("rescan_timeout", done_q[1].size() > 0, 1'b1);
    repeat (5) step();
    verify(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
